timestamped_replayer: RTL and testbench

Replays a host-decoupled stream of (data, time) tokens onto a plain clocked signal, driving each token's data once a local cycle counter reaches its timestamp. It is the counterpart of the reference timestamper: it turns a model's timestamped token stream back into a real, non-backpressurable signal for comparison or for driving reference logic. It sits between a decoupled token source and undecoupled logic in the metasimulation harness.

---
 rtl/replayer_pkg.sv | 26 ++
 rtl/timestamp_fifo.sv | 65 ++++++
 rtl/timestamped_replayer.sv | 127 ++++++++++++
 tb/tb_timestamped_replayer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/replayer_pkg.sv
// replayer_pkg
//   Shared definitions for the timestamped replayer and its token buffer.
//   TIME_WIDTH  : width of timestamps and of the local cycle counter.
//   stamp_t     : timestamp / cycle-count type.
//   stamp_due   : true when a token stamped `stamp` may be applied at `now`.
//   stamp_late  : true when applying that token at `now` misses its stamp.
//   The {data, time} token struct depends on the replayed data width, which
//   is a module parameter, so it is declared inside timestamped_replayer
//   using stamp_t from here for its time field.
package replayer_pkg;

   localparam int TIME_WIDTH = 64;

   typedef logic [TIME_WIDTH-1:0] stamp_t;

   // Unsigned compare: the counter wraps modulo 2^64 and a wrap is not an
   // error, so no attempt is made to interpret stamps across the wrap.
   function automatic logic stamp_due(input stamp_t stamp, input stamp_t now);
      return stamp <= now;
   endfunction

   function automatic logic stamp_late(input stamp_t stamp, input stamp_t now);
      return stamp < now;
   endfunction

endpackage

// File: rtl/timestamp_fifo.sv
// timestamp_fifo
//   Synchronous circular token buffer with DEPTH entries and no bypass:
//   a word pushed at an edge is first visible at head_data after that edge.
//   Pointers carry one extra wrap bit so full, empty and count fall out of a
//   plain pointer difference.
// Ports:
//   clock      in   clock
//   reset      in   synchronous, active-high; empties the buffer
//   push       in   write push_data (ignored while full)
//   push_data  in   WIDTH  word to store
//   pop        in   retire the head entry (ignored while empty)
//   head_data  out  WIDTH  oldest stored word (undefined while empty)
//   full       out  all DEPTH entries occupied
//   empty      out  no entries occupied
//   count      out  $clog2(DEPTH)+1  number of occupied entries
module timestamp_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   // DEPTH must be a power of two and at least 2, so the low AW pointer bits
   // index the storage directly and the top bit toggles once per lap.
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head_data = mem[rd_ptr[AW-1:0]];
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count     = wr_ptr - rd_ptr;

endmodule

// File: rtl/timestamped_replayer.sv
// timestamped_replayer
//   Replays a decoupled stream of (data, time) tokens onto a plain clocked
//   signal. A free-running cycle counter `now` starts at 0 in the first
//   cycle after reset; the head token is popped in the first cycle where its
//   time <= now and its data drives `value` from the next cycle on.
// Handshake: a token transfers on any cycle with timestamped_valid and
//   timestamped_ready both high; ready is simply "buffer not full" and does
//   not look at a same-cycle pop, and the source may hold or change the
//   offered token freely while ready is low.
// Ports:
//   clock                  in   clock
//   reset                  in   synchronous, active-high
//   timestamped_valid      in   token offered
//   timestamped_ready      out  buffer can accept
//   timestamped_bits_data  in   DATA_WIDTH  token data
//   timestamped_bits_time  in   64  cycle at which the data takes effect
//   value                  out  DATA_WIDTH  replayed signal (registered)
//   now                    out  64  local cycle counter (registered)
//   occupancy              out  $clog2(DEPTH)+1  buffered token count
//   late_error             out  sticky: a token was applied after its time
//   order_error            out  sticky: accepted times not strictly rising
module timestamped_replayer
   import replayer_pkg::*;
#(
   parameter int                    DATA_WIDTH = 1,
   parameter int                    DEPTH      = 16,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     timestamped_valid,
   output logic                     timestamped_ready,
   input  logic [DATA_WIDTH-1:0]    timestamped_bits_data,
   input  logic [TIME_WIDTH-1:0]    timestamped_bits_time,
   output logic [DATA_WIDTH-1:0]    value,
   output logic [TIME_WIDTH-1:0]    now,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     late_error,
   output logic                     order_error
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      stamp_t                stamp;
   } token_t;

   localparam int TOKEN_WIDTH = $bits(token_t);

   token_t                  in_token;
   token_t                  head_token;
   logic [TOKEN_WIDTH-1:0]  head_bits;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [$clog2(DEPTH):0]  fifo_count;

   logic                    push;
   logic                    pop;
   logic                    pop_late;
   logic                    out_of_order;

   stamp_t                  now_q;
   stamp_t                  last_time_q;
   logic                    has_last_q;
   logic [DATA_WIDTH-1:0]   value_q;
   logic                    late_q;
   logic                    order_q;

   assign in_token.data  = timestamped_bits_data;
   assign in_token.stamp = timestamped_bits_time;

   assign push = timestamped_valid && !fifo_full;

   timestamp_fifo #(
      .WIDTH (TOKEN_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (in_token),
      .pop       (pop),
      .head_data (head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign head_token = token_t'(head_bits);

   // Head is only examined when the buffer holds something; a token pushed
   // this cycle is not at the head yet, so there is no empty-buffer bypass.
   assign pop      = !fifo_empty && stamp_due(head_token.stamp, now_q);
   assign pop_late = pop && stamp_late(head_token.stamp, now_q);

   // A repeated or decreasing time is flagged, but the token is still taken
   // and becomes the new reference for the next comparison.
   assign out_of_order = push && has_last_q &&
                         (timestamped_bits_time <= last_time_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         now_q       <= '0;
         last_time_q <= '0;
         has_last_q  <= 1'b0;
         value_q     <= INIT_VALUE;
         late_q      <= 1'b0;
         order_q     <= 1'b0;
      end else begin
         now_q <= now_q + stamp_t'(1);
         if (push) begin
            last_time_q <= timestamped_bits_time;
            has_last_q  <= 1'b1;
         end
         if (pop)          value_q <= head_token.data;
         if (pop_late)     late_q  <= 1'b1;
         if (out_of_order) order_q <= 1'b1;
      end
   end

   assign timestamped_ready = !fifo_full;
   assign value             = value_q;
   assign now               = now_q;
   assign occupancy         = fifo_count;
   assign late_error        = late_q;
   assign order_error       = order_q;

endmodule

// File: tb/tb_timestamped_replayer.sv
module tb_timestamped_replayer;

   localparam int         DW    = 8;
   localparam int         DEPTH = 16;
   localparam logic [7:0] INIT  = 8'h3C;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        timestamped_valid = 1'b0;
   logic        timestamped_ready;
   logic [7:0]  timestamped_bits_data = '0;
   logic [63:0] timestamped_bits_time = '0;
   logic [7:0]  value;
   logic [63:0] now;
   logic [4:0]  occupancy;
   logic        late_error;
   logic        order_error;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DW-1:0] exp_q[$];

   timestamped_replayer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .INIT_VALUE (INIT)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .timestamped_valid     (timestamped_valid),
      .timestamped_ready     (timestamped_ready),
      .timestamped_bits_data (timestamped_bits_data),
      .timestamped_bits_time (timestamped_bits_time),
      .value                 (value),
      .now                   (now),
      .occupancy             (occupancy),
      .late_error            (late_error),
      .order_error           (order_error)
   );

   // clock / reset
   always #5 clock = ~clock;

   // Each tick lands 1 time unit after the active edge: outputs of the cycle
   // `cyc` are stable here and inputs driven here are sampled at the next edge.
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      timestamped_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      cyc = 0;
   endtask

   // driver tasks
   task automatic offer(input logic [7:0] d, input logic [63:0] t);
      timestamped_valid     = 1'b1;
      timestamped_bits_data = d;
      timestamped_bits_time = t;
   endtask

   task automatic idle_until(input int target);
      while (cyc < target) begin
         tick();
         timestamped_valid = 1'b0;
      end
   endtask

   // scoreboard
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_all(input logic [7:0] e_value, input logic [4:0] e_occ,
                            input logic e_ready, input logic e_late, input logic e_order);
      check("now",         now,               64'(cyc));
      check("value",       value,             64'(e_value));
      check("occupancy",   occupancy,         64'(e_occ));
      check("ready",       timestamped_ready, 64'(e_ready));
      check("late_error",  late_error,        64'(e_late));
      check("order_error", order_error,       64'(e_order));
   endtask

   typedef struct {
      int          cyc;
      logic        valid;
      logic [7:0]  data;
      logic [63:0] stamp;
      logic [7:0]  exp_value;
      logic [4:0]  exp_occ;
      logic        exp_ready;
      logic        exp_late;
      logic        exp_order;
   } vec_t;

   vec_t vecs[9];

   initial begin
      // basic on-time replay: outputs checked at the start of each listed
      // cycle, then that row's token (if any) is offered during it
      vecs[0] = '{0,  1'b0, 8'h00, 64'd0,  INIT,  5'd0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1,  1'b1, 8'h0A, 64'd10, INIT,  5'd0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{2,  1'b1, 8'h0B, 64'd20, INIT,  5'd1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{3,  1'b0, 8'h00, 64'd0,  INIT,  5'd2, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{10, 1'b0, 8'h00, 64'd0,  INIT,  5'd2, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{11, 1'b0, 8'h00, 64'd0,  8'h0A, 5'd1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{20, 1'b0, 8'h00, 64'd0,  8'h0A, 5'd1, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{21, 1'b0, 8'h00, 64'd0,  8'h0B, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{25, 1'b0, 8'h00, 64'd0,  8'h0B, 5'd0, 1'b1, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         idle_until(vecs[i].cyc);
         check_all(vecs[i].exp_value, vecs[i].exp_occ, vecs[i].exp_ready,
                   vecs[i].exp_late, vecs[i].exp_order);
         if (vecs[i].valid) offer(vecs[i].data, vecs[i].stamp);
         tick();
         timestamped_valid = 1'b0;
      end

      // late token: t=5 accepted at cycle 8, popped at 9, visible at 10
      do_reset();
      idle_until(8);
      offer(8'h01, 64'd5);
      tick();
      timestamped_valid = 1'b0;
      check_all(INIT, 5'd1, 1'b1, 1'b0, 1'b0);
      tick();
      check_all(8'h01, 5'd0, 1'b1, 1'b1, 1'b0);
      idle_until(14);
      check_all(8'h01, 5'd0, 1'b1, 1'b1, 1'b0);

      // equal timestamps: order error, second token applied one cycle late
      do_reset();
      idle_until(1);
      offer(8'h21, 64'd30);
      tick();
      offer(8'h22, 64'd30);
      tick();
      timestamped_valid = 1'b0;
      check_all(INIT, 5'd2, 1'b1, 1'b0, 1'b1);
      idle_until(31);
      check_all(8'h21, 5'd1, 1'b1, 1'b0, 1'b1);
      tick();
      check_all(8'h22, 5'd0, 1'b1, 1'b1, 1'b1);

      // DEPTH+1 tokens back to back: the last stalls until the first pop
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         check("fill_ready", timestamped_ready, 64'd1);
         check("fill_occ",   occupancy,         64'(i));
         offer(8'(i), 64'(1000 + i));
         tick();
      end
      offer(8'(DEPTH), 64'(1000 + DEPTH));
      check_all(INIT, 5'(DEPTH), 1'b0, 1'b0, 1'b0);
      while (cyc < 1000) tick();
      check_all(INIT, 5'(DEPTH), 1'b0, 1'b0, 1'b0);
      tick();
      check_all(8'd0, 5'(DEPTH - 1), 1'b1, 1'b0, 1'b0);
      tick();
      timestamped_valid = 1'b0;
      check_all(8'd1, 5'(DEPTH - 1), 1'b1, 1'b0, 1'b0);
      idle_until(1000 + DEPTH + 1);
      check_all(8'(DEPTH), 5'd0, 1'b1, 1'b0, 1'b0);

      // reset with tokens buffered and both errors set
      do_reset();
      idle_until(1);
      offer(8'h11, 64'd0);
      tick();
      offer(8'h12, 64'd0);
      tick();
      offer(8'h13, 64'd100);
      tick();
      offer(8'h14, 64'd200);
      tick();
      offer(8'h15, 64'd300);
      tick();
      timestamped_valid = 1'b0;
      idle_until(15);
      check_all(8'h12, 5'd3, 1'b1, 1'b1, 1'b1);
      reset = 1'b1;
      tick();
      cyc = 0;
      check_all(INIT, 5'd0, 1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      idle_until(310);
      check_all(INIT, 5'd0, 1'b1, 1'b0, 1'b0);

      // continuous stream t = 2k, data k: k appears at cycle 2k+1
      do_reset();
      begin
         int          k = 1;
         logic        rdy;
         logic [7:0]  last_exp = INIT;
         while (cyc < 136) begin
            if (cyc >= 3 && (cyc % 2) == 1 && ((cyc - 1) / 2) <= 64) begin
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL stream_queue cyc=%0d actual=empty required=entry", cyc);
               end else begin
                  last_exp = exp_q.pop_front();
                  check("stream_value_k", value, 64'((cyc - 1) / 2));
               end
            end
            check("stream_value", value, 64'(last_exp));
            check("stream_occ_le_depth", 64'(occupancy <= 5'(DEPTH)), 64'd1);
            rdy = timestamped_ready;
            if (k <= 64) offer(8'(k), 64'(2 * k));
            else timestamped_valid = 1'b0;
            tick();
            if (k <= 64 && rdy) begin
               exp_q.push_back(8'(k));
               k++;
            end
         end
         timestamped_valid = 1'b0;
         check("stream_late",  late_error,  64'd0);
         check("stream_order", order_error, 64'd0);
         check("stream_drain", 64'(exp_q.size()), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
